// File: rtl/axi_read_arbiter.sv
// Four-requester round-robin front end for a single-outstanding AXI read controller.
// Captures the winner's request, issues it once, forwards ID-matched beats and guards idle time.
module axi_read_arbiter #(
    parameter int addr_width = 32,
    parameter int data_width = 32,
    parameter int TIMEOUT    = 1024
) (
    input  logic                      AClk,
    input  logic                      ARst,

    input  logic [3:0]                req_valid,
    input  logic [4*addr_width-1:0]   req_addr,
    input  logic [15:0]               req_len,
    input  logic [11:0]               req_size,
    input  logic [7:0]                req_burst,
    output logic [3:0]                req_ready,

    output logic [3:0]                rsp_valid,
    output logic [3:0]                rsp_last,
    output logic [3:0]                rsp_timeout,
    output logic [data_width-1:0]     rsp_data,
    output logic [1:0]                rsp_resp,

    output logic [addr_width-1:0]     araddr_d,
    output logic [3:0]                TXN_ID_R_d,
    output logic [3:0]                arlen_d,
    output logic [2:0]                arsize_d,
    output logic [1:0]                arburst_d,
    output logic [1:0]                arlock_d,
    output logic [1:0]                arcache_d,
    output logic [2:0]                arprot_d,
    output logic                      rd_trn_en,

    input  logic [data_width-1:0]     rdata_d,
    input  logic [1:0]                rresp_d,
    input  logic [3:0]                rid_d,
    input  logic                      rd_rsp_en_d,
    input  logic                      r_last_d,

    output logic                      busy,
    output logic [1:0]                owner,
    output logic                      id_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    logic [1:0]            state_q, state_d;
    logic [1:0]            rr_q, rr_d;
    logic [1:0]            owner_q, owner_d;
    logic [15:0]           wd_q, wd_d;
    logic                  id_err_q, id_err_d;

    logic [addr_width-1:0] addr_q, addr_d;
    logic [3:0]            id_q, id_d;
    logic [3:0]            len_q, len_d;
    logic [2:0]            size_q, size_d;
    logic [1:0]            burst_q, burst_d;
    logic                  trn_en_q, trn_en_d;
    logic [3:0]            ready_q, ready_d;

    logic [3:0]            rvalid_q, rvalid_d;
    logic [3:0]            rlast_q, rlast_d;
    logic [3:0]            rtimeout_q, rtimeout_d;
    logic [data_width-1:0] rdata_q, rdata_nx;
    logic [1:0]            rresp_q, rresp_nx;

    logic                  win_found;
    logic [1:0]            win_idx;
    logic [1:0]            cand;
    logic [3:0]            own_mask;

    assign own_mask = 4'b0001 << owner_q;

    // Round-robin search starting at rr_q; the first requesting index wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = rr_q;
        cand      = rr_q;
        for (int i = 0; i < 4; i++) begin
            cand = rr_q + 2'(i);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        owner_d    = owner_q;
        wd_d       = wd_q;
        id_err_d   = id_err_q;
        addr_d     = addr_q;
        id_d       = id_q;
        len_d      = len_q;
        size_d     = size_q;
        burst_d    = burst_q;
        rdata_nx   = rdata_q;
        rresp_nx   = rresp_q;
        trn_en_d   = 1'b0;
        ready_d    = 4'b0000;
        rvalid_d   = 4'b0000;
        rlast_d    = 4'b0000;
        rtimeout_d = 4'b0000;

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    state_d  = S_ISSUE;
                    owner_d  = win_idx;
                    rr_d     = win_idx + 2'd1;
                    ready_d  = 4'b0001 << win_idx;
                    trn_en_d = 1'b1;
                    addr_d   = req_addr[int'(win_idx)*addr_width +: addr_width];
                    id_d     = {2'b00, win_idx};
                    len_d    = req_len[int'(win_idx)*4 +: 4];
                    size_d   = req_size[int'(win_idx)*3 +: 3];
                    burst_d  = req_burst[int'(win_idx)*2 +: 2];
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
                wd_d    = 16'd0;
            end
            S_WAIT: begin
                if (rd_rsp_en_d) begin
                    wd_d = 16'd0;
                    if (rid_d == id_q) begin
                        rvalid_d = own_mask;
                        rdata_nx = rdata_d;
                        rresp_nx = rresp_d;
                        if (r_last_d) begin
                            rlast_d = own_mask;
                        end
                    end else begin
                        id_err_d = 1'b1;
                    end
                    if (r_last_d) begin
                        state_d = S_DONE;
                    end
                end else if (r_last_d) begin
                    state_d = S_DONE;
                end else if (wd_q == WD_LAST) begin
                    // A stalled controller must not lock the arbiter forever.
                    rtimeout_d = own_mask;
                    state_d    = S_DONE;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                addr_d  = '0;
                id_d    = 4'd0;
                len_d   = 4'd0;
                size_d  = 3'd0;
                burst_d = 2'd0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge AClk or negedge ARst) begin
        if (!ARst) begin
            state_q    <= S_IDLE;
            rr_q       <= 2'd0;
            owner_q    <= 2'd0;
            wd_q       <= 16'd0;
            id_err_q   <= 1'b0;
            addr_q     <= '0;
            id_q       <= 4'd0;
            len_q      <= 4'd0;
            size_q     <= 3'd0;
            burst_q    <= 2'd0;
            trn_en_q   <= 1'b0;
            ready_q    <= 4'd0;
            rvalid_q   <= 4'd0;
            rlast_q    <= 4'd0;
            rtimeout_q <= 4'd0;
            rdata_q    <= '0;
            rresp_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            owner_q    <= owner_d;
            wd_q       <= wd_d;
            id_err_q   <= id_err_d;
            addr_q     <= addr_d;
            id_q       <= id_d;
            len_q      <= len_d;
            size_q     <= size_d;
            burst_q    <= burst_d;
            trn_en_q   <= trn_en_d;
            ready_q    <= ready_d;
            rvalid_q   <= rvalid_d;
            rlast_q    <= rlast_d;
            rtimeout_q <= rtimeout_d;
            rdata_q    <= rdata_nx;
            rresp_q    <= rresp_nx;
        end
    end

    assign req_ready   = ready_q;
    assign rsp_valid   = rvalid_q;
    assign rsp_last    = rlast_q;
    assign rsp_timeout = rtimeout_q;
    assign rsp_data    = rdata_q;
    assign rsp_resp    = rresp_q;

    assign araddr_d    = addr_q;
    assign TXN_ID_R_d  = id_q;
    assign arlen_d     = len_q;
    assign arsize_d    = size_q;
    assign arburst_d   = burst_q;
    assign arlock_d    = 2'b00;
    assign arcache_d   = 2'b00;
    assign arprot_d    = 3'b000;
    assign rd_trn_en   = trn_en_q;

    assign busy        = (state_q != S_IDLE);
    assign owner       = owner_q;
    assign id_err      = id_err_q;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Directed bench for axi_read_arbiter: a transaction table plus hand sequences for
// the watchdog and mid-burst reset, with a beat scoreboard checked on the falling edge.
module tb_axi_read_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic            AClk;
    logic            ARst;
    logic [3:0]      req_valid;
    logic [4*AW-1:0] req_addr;
    logic [15:0]     req_len;
    logic [11:0]     req_size;
    logic [7:0]      req_burst;
    logic [3:0]      req_ready;
    logic [3:0]      rsp_valid;
    logic [3:0]      rsp_last;
    logic [3:0]      rsp_timeout;
    logic [DW-1:0]   rsp_data;
    logic [1:0]      rsp_resp;
    logic [AW-1:0]   araddr_d;
    logic [3:0]      TXN_ID_R_d;
    logic [3:0]      arlen_d;
    logic [2:0]      arsize_d;
    logic [1:0]      arburst_d;
    logic [1:0]      arlock_d;
    logic [1:0]      arcache_d;
    logic [2:0]      arprot_d;
    logic            rd_trn_en;
    logic [DW-1:0]   rdata_d;
    logic [1:0]      rresp_d;
    logic [3:0]      rid_d;
    logic            rd_rsp_en_d;
    logic            r_last_d;
    logic            busy;
    logic [1:0]      owner;
    logic            id_err;

    axi_read_arbiter #(
        .addr_width(AW),
        .data_width(DW),
        .TIMEOUT   (16)
    ) dut (
        .AClk       (AClk),
        .ARst       (ARst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_size   (req_size),
        .req_burst  (req_burst),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_last   (rsp_last),
        .rsp_timeout(rsp_timeout),
        .rsp_data   (rsp_data),
        .rsp_resp   (rsp_resp),
        .araddr_d   (araddr_d),
        .TXN_ID_R_d (TXN_ID_R_d),
        .arlen_d    (arlen_d),
        .arsize_d   (arsize_d),
        .arburst_d  (arburst_d),
        .arlock_d   (arlock_d),
        .arcache_d  (arcache_d),
        .arprot_d   (arprot_d),
        .rd_trn_en  (rd_trn_en),
        .rdata_d    (rdata_d),
        .rresp_d    (rresp_d),
        .rid_d      (rid_d),
        .rd_rsp_en_d(rd_rsp_en_d),
        .r_last_d   (r_last_d),
        .busy       (busy),
        .owner      (owner),
        .id_err     (id_err)
    );

    typedef struct {
        logic [3:0] vec;
        int         own;
        logic [3:0] len;
        int         bad;
        bit         last_only;
    } vec_t;

    vec_t            tbl[12];
    logic [AW-1:0]   addr_tab[4];
    logic [DW+2:0]   exp_q[$];
    logic [DW+2:0]   mon_e;
    logic [1:0]      cur_owner;
    logic [3:0]      own_mask;
    bit              exp_to;
    bit              exp_id_err;
    int              checks;
    int              errors;

    assign own_mask = 4'b0001 << cur_owner;

    // Clock and run guard
    initial AClk = 1'b0;
    always #5 AClk = ~AClk;

    initial begin
        #100000;
        $display("FAIL global_guard: run did not complete within time limit");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge AClk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_rsp_bits"}, {rsp_valid, rsp_last, rsp_timeout}, 0);
        check({tag, "_rsp_payload"}, {rsp_resp, rsp_data}, 0);
        check({tag, "_araddr"}, araddr_d, 0);
        check({tag, "_ar_fields"}, {TXN_ID_R_d, arlen_d, arsize_d, arburst_d, arlock_d, arcache_d, arprot_d}, 0);
        check({tag, "_status"}, {rd_trn_en, busy, owner, id_err}, 0);
    endtask

    // Scoreboard: every forwarded beat must match the head of exp_q.
    always @(negedge AClk) begin
        if (ARst && (rsp_valid != 4'd0 || rsp_last != 4'd0)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL beat_unexpected: rsp_valid=%b rsp_last=%b rsp_data=%h", rsp_valid, rsp_last, rsp_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("beat_bits", {rsp_valid, rsp_last}, {own_mask, mon_e[DW+2] ? own_mask : 4'b0000});
                check("beat_payload", {rsp_resp, rsp_data}, mon_e[DW+1:0]);
            end
        end
        if (ARst && rsp_timeout != 4'd0 && !exp_to) begin
            checks++;
            errors++;
            $display("FAIL timeout_unexpected: rsp_timeout=%b expected 0", rsp_timeout);
        end
    end

    task automatic wait_grant(input logic [3:0] vec, input int own, input logic [3:0] len, output bit ok);
        req_valid = vec;
        req_len   = {4{len}};
        ok        = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            tick();
            if (req_ready != 4'd0) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL grant_wait: no req_ready within 8 cycles, got 0 expected %b", 4'b0001 << own);
            req_valid = 4'd0;
            return;
        end
        check("grant_req_ready", req_ready, 4'b0001 << own);
        check("grant_owner", owner, own);
        check("grant_trn_en", rd_trn_en, 1);
        check("grant_txn_id", TXN_ID_R_d, own);
        check("grant_araddr", araddr_d, addr_tab[own]);
        check("grant_ar_fields", {arlen_d, arsize_d, arburst_d}, {len, 3'(own + 1), 2'(own % 3)});
        check("grant_ar_fixed", {arlock_d, arcache_d, arprot_d}, 0);
        check("grant_busy", busy, 1);
        cur_owner      = 2'(own);
        req_valid[own] = 1'b0;
        tick();
        check("issue_pulse_end", {rd_trn_en, req_ready}, 0);
    endtask

    task automatic run_txn(input vec_t t);
        bit            ok;
        logic [DW-1:0] d;
        wait_grant(t.vec, t.own, t.len, ok);
        if (!ok) return;
        for (int k = 0; k <= int'(t.len); k++) begin
            if (k == int'(t.len) && t.last_only) begin
                rd_rsp_en_d = 1'b0;
                r_last_d    = 1'b1;
            end else begin
                d           = $urandom;
                rdata_d     = d;
                rresp_d     = 2'(k);
                rd_rsp_en_d = 1'b1;
                r_last_d    = (k == int'(t.len));
                if (k == t.bad) begin
                    rid_d      = 4'h5;
                    exp_id_err = 1'b1;
                end else begin
                    rid_d = {2'b00, 2'(t.own)};
                    exp_q.push_back({r_last_d, 2'(k), d});
                end
            end
            tick();
        end
        rd_rsp_en_d = 1'b0;
        r_last_d    = 1'b0;
        rid_d       = 4'd0;
        check("done_busy", busy, 1);
        check("done_hold_araddr", araddr_d, addr_tab[t.own]);
        tick();
        check("idle_busy", busy, 0);
        check("idle_ar_cleared", {araddr_d, TXN_ID_R_d, arlen_d, arsize_d, arburst_d}, 0);
        check("id_err", id_err, exp_id_err);
        check("sb_drain", exp_q.size(), 0);
    endtask

    initial begin
        bit ok;
        checks      = 0;
        errors      = 0;
        exp_to      = 1'b0;
        exp_id_err  = 1'b0;
        cur_owner   = 2'd0;
        req_valid   = 4'd0;
        req_len     = 16'd0;
        rdata_d     = '0;
        rresp_d     = 2'd0;
        rid_d       = 4'd0;
        rd_rsp_en_d = 1'b0;
        r_last_d    = 1'b0;
        addr_tab[0] = 32'h0000_0400;
        addr_tab[1] = 32'h0000_0800;
        addr_tab[2] = 32'h0000_1000;
        addr_tab[3] = 32'h0000_2000;
        for (int i = 0; i < 4; i++) begin
            req_addr[i*AW +: AW] = addr_tab[i];
            req_size[i*3 +: 3]   = 3'(i + 1);
            req_burst[i*2 +: 2]  = 2'(i % 3);
        end

        //            vec      own len    bad last_only
        tbl[0]  = '{4'b0100, 2, 4'd3,  -1, 1'b0};
        tbl[1]  = '{4'b0011, 0, 4'd1,  -1, 1'b0};
        tbl[2]  = '{4'b1010, 1, 4'd2,   1, 1'b0};
        tbl[3]  = '{4'b1000, 3, 4'd0,  -1, 1'b0};
        tbl[4]  = '{4'b0001, 0, 4'd0,  -1, 1'b0};
        tbl[5]  = '{4'b1111, 0, 4'd0,  -1, 1'b0};
        tbl[6]  = '{4'b1111, 1, 4'd0,  -1, 1'b0};
        tbl[7]  = '{4'b1111, 2, 4'd0,  -1, 1'b0};
        tbl[8]  = '{4'b1111, 3, 4'd0,  -1, 1'b0};
        tbl[9]  = '{4'b1111, 0, 4'd0,  -1, 1'b0};
        tbl[10] = '{4'b1110, 1, 4'd2,  -1, 1'b1};
        tbl[11] = '{4'b1100, 2, 4'd15, -1, 1'b0};

        ARst = 1'b1;
        #1 ARst = 1'b0;
        tick();
        tick();
        check_all_zero("rst_init");
        ARst = 1'b1;
        tick();

        for (int n = 0; n < 5; n++) run_txn(tbl[n]);

        // Watchdog: requester 3 wins, the controller never answers.
        wait_grant(4'b1000, 3, 4'd0, ok);
        if (ok) begin
            for (int i = 0; i < 15; i++) tick();
            check("to_not_early", rsp_timeout, 0);
            check("to_wait_busy", busy, 1);
            exp_to = 1'b1;
            tick();
            check("to_pulse", rsp_timeout, 4'b1000);
            check("to_done_busy", busy, 1);
            tick();
            check("to_pulse_end", rsp_timeout, 0);
            check("to_idle_busy", busy, 0);
            exp_to = 1'b0;
        end

        // Reset while requester 2 is mid-burst.
        wait_grant(4'b0100, 2, 4'd3, ok);
        if (ok) begin
            rdata_d     = 32'hCAFE_0001;
            rresp_d     = 2'd1;
            rid_d       = 4'h2;
            rd_rsp_en_d = 1'b1;
            exp_q.push_back({1'b0, 2'd1, 32'hCAFE_0001});
            tick();
            rd_rsp_en_d = 1'b0;
            tick();
        end
        ARst = 1'b0;
        #1;
        check_all_zero("rst_mid");
        check("rst_mid_sb", exp_q.size(), 0);
        exp_id_err = 1'b0;
        cur_owner  = 2'd0;
        tick();
        tick();
        ARst = 1'b1;

        for (int n = 5; n < 12; n++) run_txn(tbl[n]);
        req_valid = 4'd0;
        tick();
        check("end_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
